// File: rtl/conv_stream_pkg.sv
// Shared types and width helpers for the streaming convolution engine.
// Contents:
//   state_e  - engine FSM states (idle, line fill, tap-serial compute, result output)
//   idx_w()  - index width for a count of n items (never below 1 bit)
//   acc_w()  - accumulator width wide enough for K*K full-scale products
package conv_stream_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StCompute,
    StOut
  } state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned k);
    return 2 * data_w + $clog2(k * k);
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-row circular line buffer holding K x IMG_W unsigned pixels.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (clears contents)
//   we_i                write enable
//   wr_row_i, wr_col_i  write location
//   wr_data_i           pixel to store
//   rd_row_i, rd_col_i  read location (combinational read)
//   rd_data_o           pixel at the read location
module conv_line_buffer
  import conv_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned K      = 4,
  parameter int unsigned IMG_W  = 16,
  localparam int unsigned RowW  = idx_w(K),
  localparam int unsigned ColW  = idx_w(IMG_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [RowW-1:0]   wr_row_i,
  input  logic [ColW-1:0]   wr_col_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [RowW-1:0]   rd_row_i,
  input  logic [ColW-1:0]   rd_col_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [K][IMG_W];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < IMG_W; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else if (we_i) begin
      mem_q[wr_row_i][wr_col_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_row_i][rd_col_i];

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming K x K convolution engine, stride 1, no padding, KERNEL_COUNT filters in parallel.
// Pixels stream in row-major over in_valid_i/in_ready_o; each window is MAC'd one tap per
// cycle against all filters; one result vector per window leaves on out_valid_o/out_ready_i.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   start_i                       begin one image (honoured in idle only)
//   flt_wr_en_i/sel/addr/data     filter tap write (honoured in idle only), addr = row*K+col
//   in_valid_i, in_ready_o, in_data_i     unsigned pixel stream
//   out_valid_o, out_ready_i, out_data_o  signed result vector, filter 0 in the LSBs
//   busy_o                        high outside idle
//   done_o                        one-cycle pulse after the last result handshake
// Build option: define CONV_STREAM_RELU_EN to clamp negative results to zero at the output.
module conv_stream_engine
  import conv_stream_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned K            = 4,
  parameter int unsigned IMG_W        = 16,
  parameter int unsigned IMG_H        = 16,
  parameter int unsigned KERNEL_COUNT = 4,
  parameter int unsigned ACC_W        = acc_w(DATA_W, K),
  localparam int unsigned SelW        = idx_w(KERNEL_COUNT),
  localparam int unsigned TapW        = idx_w(K * K)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          flt_wr_en_i,
  input  logic [SelW-1:0]               flt_sel_i,
  input  logic [TapW-1:0]               flt_addr_i,
  input  logic [DATA_W-1:0]             flt_data_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [DATA_W-1:0]             in_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [KERNEL_COUNT*ACC_W-1:0] out_data_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned RowW = idx_w(K);
  localparam int unsigned ColW = idx_w(IMG_W);
  localparam int unsigned CntW = $clog2(IMG_H + 1);
  localparam int unsigned PrdW = 2 * DATA_W + 1;

  localparam logic [RowW-1:0] RowLast  = RowW'(K - 1);
  localparam logic [RowW:0]   RowCount = (RowW + 1)'(K);
  localparam logic [ColW-1:0] ColLast  = ColW'(IMG_W - 1);
  localparam logic [ColW-1:0] Col0Last = ColW'(IMG_W - K);
  localparam logic [CntW-1:0] KRows    = CntW'(K);
  localparam logic [CntW-1:0] ImgRows  = CntW'(IMG_H);
  localparam logic [TapW-1:0] TapLast  = TapW'(K * K - 1);

  state_e            state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   wr_row_q, wr_row_d;
  logic [CntW-1:0]   rows_seen_q, rows_seen_d;
  logic [ColW-1:0]   col0_q, col0_d;
  logic [TapW-1:0]   tap_q, tap_d;
  logic [RowW-1:0]   tr_q, tr_d;
  logic [RowW-1:0]   tc_q, tc_d;
  logic              done_q, done_d;
  logic [ACC_W-1:0]  acc_q [KERNEL_COUNT];
  logic [ACC_W-1:0]  acc_d [KERNEL_COUNT];
  logic signed [DATA_W-1:0] w_q [KERNEL_COUNT][K*K];

  logic              lb_we;
  logic [RowW:0]     row_sum;
  logic [RowW-1:0]   rd_row;
  logic [ColW-1:0]   rd_col;
  logic [DATA_W-1:0] pix;
  logic signed [PrdW-1:0] pix_ext;
  logic signed [PrdW-1:0] w_ext [KERNEL_COUNT];
  logic signed [PrdW-1:0] prod  [KERNEL_COUNT];

  // wr_row_q already points past the newest row, so it names the oldest row = window top.
  assign row_sum = {1'b0, wr_row_q} + {1'b0, tr_q};
  assign rd_row  = (row_sum >= RowCount) ? RowW'(row_sum - RowCount) : RowW'(row_sum);
  assign rd_col  = col0_q + ColW'(tc_q);
  assign lb_we   = (state_q == StFill) && in_valid_i;

  conv_line_buffer #(
    .DATA_W (DATA_W),
    .K      (K),
    .IMG_W  (IMG_W)
  ) u_line_buffer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (lb_we),
    .wr_row_i  (wr_row_q),
    .wr_col_i  (col_q),
    .wr_data_i (in_data_i),
    .rd_row_i  (rd_row),
    .rd_col_i  (rd_col),
    .rd_data_o (pix)
  );

  // MAC lanes: tap 0 restarts the accumulator so no separate clear cycle is needed.
  assign pix_ext = $signed({{DATA_W{1'b0}}, 1'b0, pix});

  always_comb begin
    for (int k = 0; k < KERNEL_COUNT; k++) begin
      w_ext[k] = {{(DATA_W + 1){w_q[k][tap_q][DATA_W-1]}}, w_q[k][tap_q]};
      prod[k]  = pix_ext * w_ext[k];
      acc_d[k] = acc_q[k];
      if (state_q == StCompute) begin
        acc_d[k] = ((tap_q == '0) ? '0 : acc_q[k]) + ACC_W'(prod[k]);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    wr_row_d    = wr_row_q;
    rows_seen_d = rows_seen_q;
    col0_d      = col0_q;
    tap_d       = tap_q;
    tr_d        = tr_q;
    tc_d        = tc_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StFill;
          col_d       = '0;
          wr_row_d    = '0;
          rows_seen_d = '0;
          col0_d      = '0;
          tap_d       = '0;
          tr_d        = '0;
          tc_d        = '0;
        end
      end
      StFill: begin
        if (in_valid_i) begin
          if (col_q == ColLast) begin
            col_d       = '0;
            wr_row_d    = (wr_row_q == RowLast) ? '0 : wr_row_q + RowW'(1);
            rows_seen_d = rows_seen_q + CntW'(1);
            if (rows_seen_d >= KRows) begin
              state_d = StCompute;
              col0_d  = '0;
            end
          end else begin
            col_d = col_q + ColW'(1);
          end
        end
      end
      StCompute: begin
        tap_d = tap_q + TapW'(1);
        if (tc_q == RowLast) begin
          tc_d = '0;
          tr_d = tr_q + RowW'(1);
        end else begin
          tc_d = tc_q + RowW'(1);
        end
        if (tap_q == TapLast) begin
          state_d = StOut;
          tap_d   = '0;
          tr_d    = '0;
          tc_d    = '0;
        end
      end
      StOut: begin
        if (out_ready_i) begin
          if (col0_q < Col0Last) begin
            col0_d  = col0_q + ColW'(1);
            state_d = StCompute;
          end else if (rows_seen_q == ImgRows) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StFill;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      col_q       <= '0;
      wr_row_q    <= '0;
      rows_seen_q <= '0;
      col0_q      <= '0;
      tap_q       <= '0;
      tr_q        <= '0;
      tc_q        <= '0;
      done_q      <= 1'b0;
      for (int k = 0; k < KERNEL_COUNT; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      wr_row_q    <= wr_row_d;
      rows_seen_q <= rows_seen_d;
      col0_q      <= col0_d;
      tap_q       <= tap_d;
      tr_q        <= tr_d;
      tc_q        <= tc_d;
      done_q      <= done_d;
      for (int k = 0; k < KERNEL_COUNT; k++) begin
        acc_q[k] <= acc_d[k];
      end
    end
  end

  // Filter register file; writes land only while idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < KERNEL_COUNT; k++) begin
        for (int t = 0; t < K * K; t++) begin
          w_q[k][t] <= '0;
        end
      end
    end else if ((state_q == StIdle) && flt_wr_en_i) begin
      w_q[flt_sel_i][flt_addr_i] <= flt_data_i;
    end
  end

  always_comb begin
    out_data_o = '0;
    for (int k = 0; k < KERNEL_COUNT; k++) begin
`ifdef CONV_STREAM_RELU_EN
      out_data_o[k*ACC_W +: ACC_W] = acc_q[k][ACC_W-1] ? '0 : acc_q[k];
`else
      out_data_o[k*ACC_W +: ACC_W] = acc_q[k];
`endif
    end
  end

  assign in_ready_o  = (state_q == StFill);
  assign out_valid_o = (state_q == StOut);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;

endmodule
